// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and defaults for the data-memory controller.
//   - FSM state encoding, access opcode
//   - default DATA_W / ADDR_W / WAIT_CYCLES
//   - address legality check used by the controller
package data_mem_ctrl_pkg;

  localparam int unsigned BYTE_ADDR_W         = 32;
  localparam int unsigned DEFAULT_DATA_W      = 32;
  localparam int unsigned DEFAULT_ADDR_W      = 8;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Bad if not word aligned or if any bit above the word index is set.
  function automatic logic addr_is_bad(input logic [BYTE_ADDR_W-1:0] addr,
                                       input int unsigned          addr_w);
    logic [BYTE_ADDR_W-1:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// MEM-stage <-> data-memory controller bus.
//   master: MEM stage (drives request, consumes result/stall)
//   slave : data_mem_ctrl
interface data_mem_ctrl_if
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

  logic                   mem_read;
  logic                   mem_write;
  logic [BYTE_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]      write_data;
  logic [DATA_W-1:0]      read_data;
  logic                   mem_stall;
  logic                   mem_done;
  logic                   addr_fault;

  modport master (
    output mem_read, mem_write, mem_addr, write_data,
    input  read_data, mem_stall, mem_done, addr_fault
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, write_data,
    output read_data, mem_stall, mem_done, addr_fault
  );

endinterface

// File: rtl/data_ram.sv
// Single-port synchronous word RAM with registered read; contents not reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, registered (value at addr on the previous edge)
module data_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller downstream of the MEM stage: fault check, wait-state
// counter and access sequencing in front of a synchronous data RAM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of data_mem_ctrl_if
//              (mem_read/mem_write/mem_addr/write_data in;
//               read_data/mem_stall/mem_done/addr_fault out)
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int unsigned     CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              mem_done_q, mem_done_d;
  logic              addr_fault_q, addr_fault_d;

  logic              req;
  logic              mem_stall;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Next-state, datapath and stall logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    read_data_d  = read_data_q;
    mem_done_d   = 1'b0;
    addr_fault_d = 1'b0;
    mem_stall    = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = waddr_q;
    req          = bus.mem_read | bus.mem_write;

    case (state_q)
      ST_IDLE: begin
        // Present the incoming address to the RAM so its registered read is
        // valid by the first WAIT cycle, even with zero wait states.
        ram_addr = bus.mem_addr[ADDR_W+1:2];
        if (req) begin
          mem_stall = 1'b1;
          op_d      = bus.mem_read ? OP_READ : OP_WRITE;
          waddr_d   = bus.mem_addr[ADDR_W+1:2];
          wdata_d   = bus.write_data;
          if (addr_is_bad(bus.mem_addr, ADDR_W)) begin
            state_d      = ST_DONE;
            mem_done_d   = 1'b1;
            addr_fault_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (cnt_q == '0) begin
          if (op_q == OP_WRITE) begin
            ram_we = ~rst;
          end else begin
            read_data_d = ram_rdata;
          end
          state_d    = ST_DONE;
          mem_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      cnt_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      read_data_q  <= '0;
      mem_done_q   <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      read_data_q  <= read_data_d;
      mem_done_q   <= mem_done_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  data_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.read_data  = read_data_q;
  assign bus.mem_stall  = mem_stall;
  assign bus.mem_done   = mem_done_q;
  assign bus.addr_fault = addr_fault_q;

endmodule
